// File: rtl/id_ex_if.sv
// Decode <-> execute boundary bundle for the ID/EX pipeline register.
// Decode drives the i_* side; the stage returns the registered o_* side.
interface id_ex_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 19
);
  logic              i_valid;
  logic [XLEN-1:0]   i_pc;
  logic [XLEN-1:0]   i_rs1_data;
  logic [XLEN-1:0]   i_rs2_data;
  logic [XLEN-1:0]   i_imm;
  logic [4:0]        i_rs1_addr;
  logic [4:0]        i_rs2_addr;
  logic [4:0]        i_rd_addr;
  logic              i_mem_read;
  logic [CTRL_W-1:0] i_ctrl;
  logic              i_flush;
  logic              i_ex_stall;

  logic              o_stall;
  logic              o_valid;
  logic [XLEN-1:0]   o_pc;
  logic [XLEN-1:0]   o_rs1_data;
  logic [XLEN-1:0]   o_rs2_data;
  logic [XLEN-1:0]   o_imm;
  logic [4:0]        o_rs1_addr;
  logic [4:0]        o_rs2_addr;
  logic [4:0]        o_rd_addr;
  logic              o_mem_read;
  logic [CTRL_W-1:0] o_ctrl;

  modport master (
    output i_valid, i_pc, i_rs1_data, i_rs2_data, i_imm,
    output i_rs1_addr, i_rs2_addr, i_rd_addr,
    output i_mem_read, i_ctrl, i_flush, i_ex_stall,
    input  o_stall, o_valid, o_pc, o_rs1_data, o_rs2_data,
    input  o_imm, o_rs1_addr, o_rs2_addr, o_rd_addr,
    input  o_mem_read, o_ctrl
  );

  modport slave (
    input  i_valid, i_pc, i_rs1_data, i_rs2_data, i_imm,
    input  i_rs1_addr, i_rs2_addr, i_rd_addr,
    input  i_mem_read, i_ctrl, i_flush, i_ex_stall,
    output o_stall, o_valid, o_pc, o_rs1_data, o_rs2_data,
    output o_imm, o_rs1_addr, o_rs2_addr, o_rd_addr,
    output o_mem_read, o_ctrl
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble, flush and
// execute back-pressure hold.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 19
) (
  input logic   i_clk,
  input logic   i_rst,
  id_ex_if.slave bus
);
  logic              valid_q, valid_d;
  logic              mem_read_q, mem_read_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [4:0]        rs1_addr_q, rs1_addr_d;
  logic [4:0]        rs2_addr_q, rs2_addr_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  logic              hazard;
  logic              rd_hit;

  // Load in EX whose rd feeds the instruction sitting in decode.
  always_comb begin
    rd_hit = (rd_addr_q == bus.i_rs1_addr) |
             (rd_addr_q == bus.i_rs2_addr);
    hazard = valid_q & mem_read_q & (rd_addr_q != 5'd0) &
             bus.i_valid & rd_hit;
  end

  assign bus.o_stall = (hazard | bus.i_ex_stall) &
                       ~bus.i_flush & ~i_rst;

  always_comb begin
    valid_d    = valid_q;
    mem_read_d = mem_read_q;
    ctrl_d     = ctrl_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    rd_addr_d  = rd_addr_q;
    priority case (1'b1)
      bus.i_flush: begin
        valid_d    = 1'b0;
        mem_read_d = 1'b0;
        ctrl_d     = '0;
      end
      bus.i_ex_stall: begin
      end
      hazard: begin
        valid_d    = 1'b0;
        mem_read_d = 1'b0;
        ctrl_d     = '0;
      end
      default: begin
        valid_d    = bus.i_valid;
        mem_read_d = bus.i_valid & bus.i_mem_read;
        ctrl_d     = bus.i_valid ? bus.i_ctrl : '0;
        pc_d       = bus.i_pc;
        rs1_data_d = bus.i_rs1_data;
        rs2_data_d = bus.i_rs2_data;
        imm_d      = bus.i_imm;
        rs1_addr_d = bus.i_rs1_addr;
        rs2_addr_d = bus.i_rs2_addr;
        rd_addr_d  = bus.i_rd_addr;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q    <= 1'b0;
      mem_read_q <= 1'b0;
      ctrl_q     <= '0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      mem_read_q <= mem_read_d;
      ctrl_q     <= ctrl_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  assign bus.o_valid    = valid_q;
  assign bus.o_mem_read = mem_read_q;
  assign bus.o_ctrl     = ctrl_q;
  assign bus.o_pc       = pc_q;
  assign bus.o_rs1_data = rs1_data_q;
  assign bus.o_rs2_data = rs2_data_q;
  assign bus.o_imm      = imm_q;
  assign bus.o_rs1_addr = rs1_addr_q;
  assign bus.o_rs2_addr = rs2_addr_q;
  assign bus.o_rd_addr  = rd_addr_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for the ID/EX pipeline register.
// Inputs change 1 time unit after the rising edge.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;

  id_ex_if #(.XLEN(32), .CTRL_W(19)) bus ();

  id_ex_stage #(.XLEN(32), .CTRL_W(19)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic        v,
                       input logic [31:0] pc,
                       input logic [4:0]  rs1,
                       input logic [4:0]  rs2,
                       input logic [4:0]  rd,
                       input logic        mr,
                       input logic [18:0] ctrl);
    bus.i_valid    = v;
    bus.i_pc       = pc;
    bus.i_rs1_data = pc ^ 32'h1111_0000;
    bus.i_rs2_data = pc ^ 32'h2222_0000;
    bus.i_imm      = pc + 32'd4;
    bus.i_rs1_addr = rs1;
    bus.i_rs2_addr = rs2;
    bus.i_rd_addr  = rd;
    bus.i_mem_read = mr;
    bus.i_ctrl     = ctrl;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 19'h0);
    bus.i_flush    = 1'b0;
    bus.i_ex_stall = 1'b1;
    step();
    step();
    check("rst_valid", {31'b0, bus.o_valid}, 32'h0);
    check("rst_ctrl", {13'b0, bus.o_ctrl}, 32'h0);
    check("rst_pc", bus.o_pc, 32'h0);
    check("rst_stall", {31'b0, bus.o_stall}, 32'h0);
    bus.i_ex_stall = 1'b0;
    rst = 1'b0;
    step();

    // pass-through
    drive(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 1'b0, 19'h12345);
    bus.i_imm = 32'hFFFF_FFF0;
    #1 check("pt_stall0", {31'b0, bus.o_stall}, 32'h0);
    step();
    check("pt_pc", bus.o_pc, 32'h100);
    check("pt_imm", bus.o_imm, 32'hFFFF_FFF0);
    check("pt_ctrl", {13'b0, bus.o_ctrl}, 32'h12345);
    check("pt_valid", {31'b0, bus.o_valid}, 32'h1);
    check("pt_rs1d", bus.o_rs1_data, 32'h1111_0100);
    check("pt_rd", {27'b0, bus.o_rd_addr}, 32'd3);
    check("pt_stall", {31'b0, bus.o_stall}, 32'h0);

    // asynchronous reset mid-stream
    #1 rst = 1'b1;
    #1;
    check("arst_valid", {31'b0, bus.o_valid}, 32'h0);
    check("arst_ctrl", {13'b0, bus.o_ctrl}, 32'h0);
    rst = 1'b0;
    step();

    // invalid slot loads with ctrl forced to zero
    drive(1'b0, 32'h0FC, 5'd1, 5'd2, 5'd3, 1'b1, 19'h7FFFF);
    step();
    check("inv_valid", {31'b0, bus.o_valid}, 32'h0);
    check("inv_ctrl", {13'b0, bus.o_ctrl}, 32'h0);
    check("inv_mr", {31'b0, bus.o_mem_read}, 32'h0);

    // load-use: lw x5 then add rs1=x5
    drive(1'b1, 32'h104, 5'd1, 5'd0, 5'd5, 1'b1, 19'h00300);
    step();
    drive(1'b1, 32'h108, 5'd5, 5'd6, 5'd7, 1'b0, 19'h00100);
    #1 check("lu_stall", {31'b0, bus.o_stall}, 32'h1);
    step();
    check("lu_bub_valid", {31'b0, bus.o_valid}, 32'h0);
    check("lu_bub_ctrl", {13'b0, bus.o_ctrl}, 32'h0);
    check("lu_bub_mr", {31'b0, bus.o_mem_read}, 32'h0);
    check("lu_stall_clr", {31'b0, bus.o_stall}, 32'h0);
    step();
    check("lu_valid", {31'b0, bus.o_valid}, 32'h1);
    check("lu_pc", bus.o_pc, 32'h108);
    check("lu_ctrl", {13'b0, bus.o_ctrl}, 32'h00100);

    // store consuming a load rd through rs2
    drive(1'b1, 32'h10C, 5'd1, 5'd0, 5'd9, 1'b1, 19'h00300);
    step();
    drive(1'b1, 32'h110, 5'd2, 5'd9, 5'd0, 1'b0, 19'h00800);
    #1 check("st_stall", {31'b0, bus.o_stall}, 32'h1);
    step();
    check("st_bub", {31'b0, bus.o_valid}, 32'h0);
    step();
    check("st_pc", bus.o_pc, 32'h110);

    // load into x0 never hazards
    drive(1'b1, 32'h114, 5'd1, 5'd0, 5'd0, 1'b1, 19'h00300);
    step();
    drive(1'b1, 32'h118, 5'd0, 5'd0, 5'd4, 1'b0, 19'h00100);
    #1 check("x0_stall", {31'b0, bus.o_stall}, 32'h0);
    step();
    check("x0_valid", {31'b0, bus.o_valid}, 32'h1);
    check("x0_pc", bus.o_pc, 32'h118);

    // flush beats hazard
    drive(1'b1, 32'h11C, 5'd1, 5'd0, 5'd5, 1'b1, 19'h00300);
    step();
    drive(1'b1, 32'h120, 5'd5, 5'd0, 5'd6, 1'b0, 19'h00100);
    bus.i_flush = 1'b1;
    #1 check("fl_stall", {31'b0, bus.o_stall}, 32'h0);
    step();
    bus.i_flush = 1'b0;
    check("fl_valid", {31'b0, bus.o_valid}, 32'h0);
    check("fl_ctrl", {13'b0, bus.o_ctrl}, 32'h0);

    // execute back-pressure holds three cycles
    drive(1'b1, 32'h200, 5'd1, 5'd2, 5'd3, 1'b0, 19'h0ABCD);
    step();
    check("hs_pc0", bus.o_pc, 32'h200);
    drive(1'b1, 32'h204, 5'd4, 5'd5, 5'd6, 1'b0, 19'h00111);
    bus.i_ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("hs_stall", {31'b0, bus.o_stall}, 32'h1);
      step();
      check("hs_pc", bus.o_pc, 32'h200);
      check("hs_ctrl", {13'b0, bus.o_ctrl}, 32'h0ABCD);
    end
    bus.i_ex_stall = 1'b0;
    #1 check("hs_rel_stall", {31'b0, bus.o_stall}, 32'h0);
    step();
    check("hs_rel_pc", bus.o_pc, 32'h204);
    check("hs_rel_ctrl", {13'b0, bus.o_ctrl}, 32'h00111);

    // back-pressure with hazard: hold, then bubble on release
    drive(1'b1, 32'h300, 5'd1, 5'd0, 5'd8, 1'b1, 19'h00300);
    step();
    drive(1'b1, 32'h304, 5'd8, 5'd0, 5'd9, 1'b0, 19'h00100);
    bus.i_ex_stall = 1'b1;
    #1 check("hz_hold_stall", {31'b0, bus.o_stall}, 32'h1);
    step();
    check("hz_hold_valid", {31'b0, bus.o_valid}, 32'h1);
    check("hz_hold_mr", {31'b0, bus.o_mem_read}, 32'h1);
    check("hz_hold_pc", bus.o_pc, 32'h300);
    bus.i_ex_stall = 1'b0;
    #1 check("hz_rel_stall", {31'b0, bus.o_stall}, 32'h1);
    step();
    check("hz_bub", {31'b0, bus.o_valid}, 32'h0);
    step();
    check("hz_load_pc", bus.o_pc, 32'h304);
    check("hz_load_v", {31'b0, bus.o_valid}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
